// File: rtl/grid_collect_pkg.sv
// Shared types and helpers for the grid signature collector: FSM state,
// the running signature of a capture window and its byte serialisation.
package grid_collect_pkg;

    localparam int BYTE_W       = 8;
    localparam int SUM_W        = 16;
    localparam int RECORD_BYTES = 4;

    // Counts samples 0..255, enough for the largest legal window of 256.
    localparam int SAMPLE_CNT_W = 8;
    localparam int BYTE_IDX_W   = $clog2(RECORD_BYTES);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        PACK    = 2'd2
    } state_e;

    // Running signature of one window.
    typedef struct packed {
        logic [SUM_W-1:0]  sum;
        logic [BYTE_W-1:0] xor_acc;
        logic [BYTE_W-1:0] max_val;
    } signature_t;

    // Fold one sample into the signature: modular sum, xor, unsigned max.
    function automatic signature_t sample_update(input signature_t sig,
                                                 input logic [BYTE_W-1:0] sample);
        signature_t nxt;
        nxt.sum     = sig.sum + SUM_W'(sample);
        nxt.xor_acc = sig.xor_acc ^ sample;
        nxt.max_val = (sample > sig.max_val) ? sample : sig.max_val;
        return nxt;
    endfunction

    // Record byte order: sum high, sum low, xor, max.
    function automatic logic [BYTE_W-1:0] record_byte(input signature_t sig,
                                                      input logic [BYTE_IDX_W-1:0] idx);
        logic [BYTE_W-1:0] b;
        case (idx)
            BYTE_IDX_W'(0): b = sig.sum[SUM_W-1 -: BYTE_W];
            BYTE_IDX_W'(1): b = sig.sum[BYTE_W-1:0];
            BYTE_IDX_W'(2): b = sig.xor_acc;
            default:        b = sig.max_val;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/grid_byte_fifo.sv
// Synchronous byte FIFO with a registered head. The head register always
// holds the oldest entry while non-empty, so the consumer sees a flop output.
// Push is refused when full and pop is ignored when empty; a pop on a full
// cycle only makes room for the following cycle.
module grid_byte_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic             full_q,   full_d;
    logic             empty_q,  empty_d;
    logic [WIDTH-1:0] head_q,   head_d;

    logic push_ok;
    logic pop_ok;

    assign push_ok = push && !full_q;
    assign pop_ok  = pop  && !empty_q;

    // Next-state for pointers, occupancy flags and the head register.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned and no latch is inferred.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        head_d   = head_q;
        count_d  = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);

        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end

        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (count_q == CNT_W'(1)) begin
                // Last stored entry leaves; a simultaneous push becomes the new head.
                if (push_ok) begin
                    head_d = wdata;
                end
            end else begin
                head_d = mem_q[rd_ptr_q + PTR_W'(1)];
            end
        end else if (push_ok && empty_q) begin
            head_d = wdata;
        end

        full_d  = (count_d == CNT_W'(DEPTH));
        empty_d = (count_d == '0);
    end

    // Storage array: written on accepted pushes only.
    always_ff @(posedge clk) begin
        // NOTE: the storage array is deliberately not reset; nothing is read from it until the pointers mark it valid.
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    // Pointer, occupancy and head registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            head_q   <= head_d;
        end
    end

    assign full  = full_q;
    assign empty = empty_q;
    assign head  = head_q;

endmodule

// File: rtl/grid_signature_collector.sv
// Captures a window of NUM_SAMPLES bytes from the grid core array, folds
// them into a sum/xor/max signature and streams it out as a 4-byte record
// through a small output FIFO. busy and done come straight from flops and
// out_data/out_valid from the FIFO's registers, so data_in never reaches an
// output combinationally.
module grid_signature_collector
    import grid_collect_pkg::*;
#(
    parameter int NUM_SAMPLES = 64,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [BYTE_W-1:0] data_in,
    input  logic              start,
    output logic [BYTE_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
);

    localparam logic [SAMPLE_CNT_W-1:0] LAST_SAMPLE = SAMPLE_CNT_W'(NUM_SAMPLES - 1);
    localparam logic [BYTE_IDX_W-1:0]   LAST_BYTE   = BYTE_IDX_W'(RECORD_BYTES - 1);

    state_e                  state_q;
    signature_t              sig_q;
    logic [SAMPLE_CNT_W-1:0] cnt_q;
    logic [BYTE_IDX_W-1:0]   idx_q;
    logic                    busy_q;
    logic                    done_q;

    logic              fifo_full;
    logic              fifo_empty;
    logic [BYTE_W-1:0] fifo_head;
    logic              fifo_push;
    logic              fifo_pop;
    logic [BYTE_W-1:0] push_byte;

    // One record byte per cycle while packing, held back whenever the FIFO is full.
    assign fifo_push = (state_q == PACK) && !fifo_full;
    assign push_byte = record_byte(sig_q, idx_q);
    assign fifo_pop  = !fifo_empty && out_ready;

    // Window FSM: start -> capture NUM_SAMPLES samples -> pack 4 bytes -> idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sig_q   <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= CAPTURE;
                        busy_q  <= 1'b1;
                        sig_q   <= '0;
                        cnt_q   <= '0;
                    end
                end
                CAPTURE: begin
                    sig_q <= sample_update(sig_q, data_in);
                    cnt_q <= cnt_q + SAMPLE_CNT_W'(1);
                    if (cnt_q == LAST_SAMPLE) begin
                        state_q <= PACK;
                        idx_q   <= '0;
                    end
                end
                PACK: begin
                    if (!fifo_full) begin
                        idx_q <= idx_q + BYTE_IDX_W'(1);
                        if (idx_q == LAST_BYTE) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    grid_byte_fifo #(
        .WIDTH (BYTE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .wdata (push_byte),
        .pop   (fifo_pop),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (fifo_head)
    );

    assign out_data  = fifo_head;
    assign out_valid = !fifo_empty;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_grid_signature_collector.sv
// Bench for grid_signature_collector. Three instances cover window sizes
// 4, 64 (default) and 1. Expected record bytes are queued per instance when
// a window is started and compared as the consumer accepts them.
module tb_grid_signature_collector;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start_s [3];
    logic [7:0] din_s   [3];
    logic       rdy_s   [3];
    logic [7:0] dout_s  [3];
    logic       vld_s   [3];
    logic       busy_s  [3];
    logic       done_s  [3];

    int total = 0;
    int bad   = 0;
    int done_cnt [3];
    int exp_done [3];

    logic [7:0] q0 [$];
    logic [7:0] q1 [$];
    logic [7:0] q2 [$];
    logic [7:0] win [$];
    bit         rand_stop;

    grid_signature_collector #(.NUM_SAMPLES(4), .FIFO_DEPTH(4)) dut_ns4 (
        .clk(clk), .rst(rst), .data_in(din_s[0]), .start(start_s[0]),
        .out_data(dout_s[0]), .out_valid(vld_s[0]), .out_ready(rdy_s[0]),
        .busy(busy_s[0]), .done(done_s[0])
    );

    grid_signature_collector dut_def (
        .clk(clk), .rst(rst), .data_in(din_s[1]), .start(start_s[1]),
        .out_data(dout_s[1]), .out_valid(vld_s[1]), .out_ready(rdy_s[1]),
        .busy(busy_s[1]), .done(done_s[1])
    );

    grid_signature_collector #(.NUM_SAMPLES(1), .FIFO_DEPTH(4)) dut_ns1 (
        .clk(clk), .rst(rst), .data_in(din_s[2]), .start(start_s[2]),
        .out_data(dout_s[2]), .out_valid(vld_s[2]), .out_ready(rdy_s[2]),
        .busy(busy_s[2]), .done(done_s[2])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic int qsize(input int w);
        case (w)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic logic [7:0] qfront(input int w);
        case (w)
            0:       return q0[0];
            1:       return q1[0];
            default: return q2[0];
        endcase
    endfunction

    task automatic push_exp(input int w, input logic [7:0] b);
        case (w)
            0:       q0.push_back(b);
            1:       q1.push_back(b);
            default: q2.push_back(b);
        endcase
    endtask

    task automatic pop_check(input int w, input logic [7:0] got);
        logic [7:0] e;
        if (qsize(w) == 0) begin
            check($sformatf("d%0d_extra_byte", w), {24'd0, got}, 32'h100);
        end else begin
            case (w)
                0:       e = q0.pop_front();
                1:       e = q1.pop_front();
                default: e = q2.pop_front();
            endcase
            check($sformatf("d%0d_byte", w), {24'd0, got}, {24'd0, e});
        end
    endtask

    // Literal expected record for the fixed vectors.
    task automatic expect_bytes(input int w, input logic [7:0] b0, input logic [7:0] b1,
                                input logic [7:0] b2, input logic [7:0] b3);
        push_exp(w, b0);
        push_exp(w, b1);
        push_exp(w, b2);
        push_exp(w, b3);
        exp_done[w]++;
    endtask

    // Reference signature of the samples in win.
    task automatic model_window(input int w);
        logic [15:0] s;
        logic [7:0]  x;
        logic [7:0]  m;
        s = '0;
        x = '0;
        m = '0;
        for (int i = 0; i < win.size(); i++) begin
            s = s + {8'd0, win[i]};
            x = x ^ win[i];
            if (win[i] > m) m = win[i];
        end
        expect_bytes(w, s[15:8], s[7:0], x, m);
    endtask

    task automatic wait_idle(input int w, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (busy_s[w] === 1'b0) break;
            @(posedge clk);
            #1;
        end
        check($sformatf("d%0d_idle_wait", w), {31'd0, busy_s[w]}, 32'd0);
    endtask

    task automatic wait_drain(input int w, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (qsize(w) == 0 && vld_s[w] === 1'b0 && busy_s[w] === 1'b0) break;
            @(posedge clk);
            #1;
        end
        check($sformatf("d%0d_drain_left", w), qsize(w), 32'd0);
        check($sformatf("d%0d_drain_busy", w), {31'd0, busy_s[w]}, 32'd0);
    endtask

    // Start one window with the samples in win; returns just after the edge
    // that takes the last sample. glitch pulses start mid-capture.
    task automatic run_window(input int w, input bit glitch, input bit record);
        wait_idle(w, 3000);
        if (record) model_window(w);
        @(posedge clk); #1;
        start_s[w] = 1'b1;
        @(posedge clk); #1;
        start_s[w] = 1'b0;
        din_s[w]   = win[0];
        for (int i = 1; i < win.size(); i++) begin
            @(posedge clk); #1;
            din_s[w] = win[i];
            if (glitch) start_s[w] = (i == 1);
        end
        @(posedge clk); #1;
        start_s[w] = 1'b0;
        check($sformatf("d%0d_busy_pack", w), {31'd0, busy_s[w]}, 32'd1);
    endtask

    // Consumer side: a byte is taken on the next rising edge when valid && ready.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            for (int w = 0; w < 3; w++) begin
                if (vld_s[w] === 1'b1 && rdy_s[w] === 1'b1) pop_check(w, dout_s[w]);
                if (done_s[w] === 1'b1) done_cnt[w]++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        rand_stop = 1'b0;
        for (int w = 0; w < 3; w++) begin
            start_s[w]  = 1'b0;
            din_s[w]    = 8'h00;
            rdy_s[w]    = 1'b0;
            done_cnt[w] = 0;
            exp_done[w] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int w = 0; w < 3; w++) begin
            check($sformatf("d%0d_rst_valid", w), {31'd0, vld_s[w]},  32'd0);
            check($sformatf("d%0d_rst_data", w),  {24'd0, dout_s[w]}, 32'd0);
            check($sformatf("d%0d_rst_busy", w),  {31'd0, busy_s[w]}, 32'd0);
            check($sformatf("d%0d_rst_done", w),  {31'd0, done_s[w]}, 32'd0);
        end
        rst = 1'b0;

        // 1,2,3,4 with a ready consumer; first byte one cycle after entering PACK.
        rdy_s[0] = 1'b1;
        win = {8'h01, 8'h02, 8'h03, 8'h04};
        expect_bytes(0, 8'h00, 8'h0A, 8'h04, 8'h04);
        run_window(0, 1'b0, 1'b0);
        check("a_lat_pre_valid", {31'd0, vld_s[0]}, 32'd0);
        @(posedge clk); #1;
        check("a_lat_valid", {31'd0, vld_s[0]}, 32'd1);
        check("a_lat_byte", {24'd0, dout_s[0]}, 32'h00);
        @(posedge clk); #1;
        check("a_second_byte", {24'd0, dout_s[0]}, 32'h0A);
        wait_drain(0, 50);
        check("a_done_count", done_cnt[0], exp_done[0]);

        // Default 64-sample window of 0xFF.
        rdy_s[1] = 1'b1;
        win.delete();
        repeat (64) win.push_back(8'hFF);
        expect_bytes(1, 8'h3F, 8'hC0, 8'h00, 8'hFF);
        run_window(1, 1'b0, 1'b0);
        wait_drain(1, 50);
        check("b_done_count", done_cnt[1], exp_done[1]);

        // Stalled consumer: first record fills the FIFO, second stalls in PACK.
        rdy_s[0] = 1'b0;
        win = {8'h05, 8'h06, 8'h07, 8'h08};
        run_window(0, 1'b0, 1'b1);
        wait_idle(0, 20);
        check("c_full_valid", {31'd0, vld_s[0]}, 32'd1);
        win = {8'h11, 8'h22, 8'h33, 8'h44};
        run_window(0, 1'b0, 1'b1);
        repeat (6) @(posedge clk);
        #1;
        check("c_stall_busy", {31'd0, busy_s[0]}, 32'd1);
        check("c_stall_valid", {31'd0, vld_s[0]}, 32'd1);
        check("c_stall_head", {24'd0, dout_s[0]}, {24'd0, qfront(0)});
        check("c_stall_done", done_cnt[0], exp_done[0] - 1);
        rdy_s[0] = 1'b1;
        wait_drain(0, 100);
        check("c_done_count", done_cnt[0], exp_done[0]);

        // Reset after two samples discards the window.
        wait_idle(0, 20);
        @(posedge clk); #1;
        start_s[0] = 1'b1;
        @(posedge clk); #1;
        start_s[0] = 1'b0;
        din_s[0]   = 8'h33;
        @(posedge clk); #1;
        din_s[0] = 8'h44;
        @(posedge clk); #1;
        check("d_mid_capture_busy", {31'd0, busy_s[0]}, 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("d_rst_busy", {31'd0, busy_s[0]}, 32'd0);
        check("d_rst_valid", {31'd0, vld_s[0]}, 32'd0);

        // Reset mid-PACK drops the partial record; rst beats start and out_ready.
        rdy_s[0] = 1'b0;
        win = {8'h09, 8'h09, 8'h09, 8'h09};
        run_window(0, 1'b0, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("d_partial_valid", {31'd0, vld_s[0]}, 32'd1);
        rst        = 1'b1;
        start_s[0] = 1'b1;
        rdy_s[0]   = 1'b1;
        @(posedge clk); #1;
        rst        = 1'b0;
        start_s[0] = 1'b0;
        check("d_rst2_busy", {31'd0, busy_s[0]}, 32'd0);
        check("d_rst2_valid", {31'd0, vld_s[0]}, 32'd0);
        check("d_rst2_data", {24'd0, dout_s[0]}, 32'h00);
        @(posedge clk); #1;
        check("d_start_overridden", {31'd0, busy_s[0]}, 32'd0);
        win = {8'h10, 8'h10, 8'h10, 8'h10};
        expect_bytes(0, 8'h00, 8'h40, 8'h00, 8'h10);
        run_window(0, 1'b0, 1'b0);
        wait_drain(0, 50);
        check("d_done_count", done_cnt[0], exp_done[0]);

        // start pulses during CAPTURE and PACK are ignored.
        win = {8'hA0, 8'h05, 8'h5A, 8'h0F};
        run_window(0, 1'b1, 1'b1);
        start_s[0] = 1'b1;
        @(posedge clk); #1;
        start_s[0] = 1'b0;
        wait_drain(0, 50);
        repeat (5) @(posedge clk);
        #1;
        check("e_no_extra_window", {31'd0, busy_s[0]}, 32'd0);
        check("e_no_extra_bytes", {31'd0, vld_s[0]}, 32'd0);
        check("e_done_count", done_cnt[0], exp_done[0]);

        // Single-sample windows under a randomly toggling consumer.
        fork
            begin
                while (!rand_stop) begin
                    @(posedge clk); #1;
                    rdy_s[2] = 1'($urandom_range(0, 1));
                end
            end
        join_none
        win = {8'h80};
        expect_bytes(2, 8'h00, 8'h80, 8'h80, 8'h80);
        run_window(2, 1'b0, 1'b0);
        for (int k = 0; k < 10; k++) begin
            win = {8'($urandom_range(0, 255))};
            run_window(2, 1'b0, 1'b1);
        end
        rand_stop = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rdy_s[2] = 1'b1;
        wait_drain(2, 200);

        for (int w = 0; w < 3; w++) begin
            check($sformatf("d%0d_final_queue", w), qsize(w), 32'd0);
            check($sformatf("d%0d_final_done", w), done_cnt[w], exp_done[w]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
